// File: rtl/store_commit_ctrl.sv
// Store commit controller: buffers retiring stores and writes them to the D-cache one at a time, in retire order.
// Optional STORE_COMMIT_BYPASS_EN presents lane 0 on dc_req in its arrival cycle when the buffer is empty.
module store_commit_ctrl #(
  parameter int N_WAY = 2,
  parameter int DEPTH = 4,
  parameter int POS_W = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N_WAY-1:0]               ret_valid,
  input  logic [N_WAY*32-1:0]            ret_addr,
  input  logic [N_WAY*32-1:0]            ret_data,
  input  logic [N_WAY*2-1:0]             ret_size,
  input  logic [N_WAY*POS_W-1:0]         ret_pos,
  output logic [$clog2(DEPTH):0]         free_slots,
  output logic                           dc_req_valid,
  output logic [31:0]                    dc_req_addr,
  output logic [31:0]                    dc_req_data,
  output logic [1:0]                     dc_req_size,
  input  logic                           dc_req_ready,
  input  logic                           dc_ack,
  output logic                           done_valid,
  output logic [POS_W-1:0]               done_pos,
  output logic                           idle,
  output logic                           overflow_err
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state;

  logic [31:0]      mem_addr [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [1:0]       mem_size [DEPTH];
  logic [POS_W-1:0] mem_pos  [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count, count_next, push_cnt, free_cnt;
  logic [N_WAY-1:0] lane_we, lane_drop;
  logic [PTR_W-1:0] lane_slot [N_WAY];
  logic             pop, bypass;

  // Valid lanes are compacted into consecutive tail slots; capacity is judged
  // against the registered count only, so a same-cycle pop frees nothing.
  always_comb begin
    free_cnt  = CNT_W'(DEPTH) - count;
    push_cnt  = '0;
    lane_we   = '0;
    lane_drop = '0;
    for (int i = 0; i < N_WAY; i++) begin
      lane_slot[i] = tail + push_cnt[PTR_W-1:0];
      if (ret_valid[i]) begin
        if (push_cnt < free_cnt) begin
          lane_we[i] = 1'b1;
          push_cnt   = push_cnt + CNT_W'(1);
        end else begin
          lane_drop[i] = 1'b1;
        end
      end
    end
  end

  assign pop        = (state == S_WAIT) && dc_ack;
  assign count_next = count + push_cnt - CNT_W'(pop);

`ifdef STORE_COMMIT_BYPASS_EN
  assign bypass = (state == S_IDLE) && (count == '0) && ret_valid[0];
`else
  assign bypass = 1'b0;
`endif

  // Handshake: a request transfers on a cycle where dc_req_valid && dc_req_ready;
  // fields hold steady while valid is high and ready is low. dc_ack later marks
  // the write complete and only counts while a request is outstanding.
  assign dc_req_valid = (state == S_REQ) || bypass;
  assign dc_req_addr  = bypass ? ret_addr[31:0] : mem_addr[head];
  assign dc_req_data  = bypass ? ret_data[31:0] : mem_data[head];
  assign dc_req_size  = bypass ? ret_size[1:0]  : mem_size[head];
  assign free_slots   = free_cnt;
  assign idle         = (count == '0) && (state == S_IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_WAY; i++) begin
        if (lane_we[i]) begin
          mem_addr[lane_slot[i]] <= ret_addr[i*32 +: 32];
          mem_data[lane_slot[i]] <= ret_data[i*32 +: 32];
          mem_size[lane_slot[i]] <= ret_size[i*2 +: 2];
          mem_pos[lane_slot[i]]  <= ret_pos[i*POS_W +: POS_W];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      state        <= S_IDLE;
      done_valid   <= 1'b0;
      done_pos     <= '0;
      overflow_err <= 1'b0;
    end else begin
      tail       <= tail + push_cnt[PTR_W-1:0];
      count      <= count_next;
      done_valid <= pop;
      if (|lane_drop) overflow_err <= 1'b1;
      if (pop) begin
        head     <= head + PTR_W'(1);
        done_pos <= mem_pos[head];
      end
      case (state)
        S_IDLE: begin
          if (bypass) state <= dc_req_ready ? S_WAIT : S_REQ;
          else if (count != '0) state <= S_REQ;
        end
        S_REQ:  if (dc_req_ready) state <= S_WAIT;
        S_WAIT: if (dc_ack) state <= (count_next != '0) ? S_REQ : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_commit_ctrl.sv
// Randomized bench for store_commit_ctrl: a queue-based model of the commit buffer
// predicts accepted stores, request contents, completion order and flags.
module tb_store_commit_ctrl;
  localparam int N_WAY = 2;
  localparam int DEPTH = 4;
  localparam int POS_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int RQ_W  = 66;
  localparam int ST_W  = RQ_W + POS_W;

  logic                   clock;
  logic                   reset;
  logic [N_WAY-1:0]       ret_valid;
  logic [N_WAY*32-1:0]    ret_addr;
  logic [N_WAY*32-1:0]    ret_data;
  logic [N_WAY*2-1:0]     ret_size;
  logic [N_WAY*POS_W-1:0] ret_pos;
  logic [CW-1:0]          free_slots;
  logic                   dc_req_valid;
  logic [31:0]            dc_req_addr;
  logic [31:0]            dc_req_data;
  logic [1:0]             dc_req_size;
  logic                   dc_req_ready;
  logic                   dc_ack;
  logic                   done_valid;
  logic [POS_W-1:0]       done_pos;
  logic                   idle;
  logic                   overflow_err;

  store_commit_ctrl #(.N_WAY(N_WAY), .DEPTH(DEPTH), .POS_W(POS_W)) dut (
    .clock(clock), .reset(reset),
    .ret_valid(ret_valid), .ret_addr(ret_addr), .ret_data(ret_data),
    .ret_size(ret_size), .ret_pos(ret_pos), .free_slots(free_slots),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_size(dc_req_size),
    .dc_req_ready(dc_req_ready), .dc_ack(dc_ack),
    .done_valid(done_valid), .done_pos(done_pos),
    .idle(idle), .overflow_err(overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: buffered stores {addr, data, size, pos} in retire order.
  logic [ST_W-1:0]  exp_q[$];
  logic [POS_W-1:0] done_log[$];
  bit               outstanding, exp_done, exp_ovf, prev_stall;
  logic [POS_W-1:0] exp_done_pos;
  logic [RQ_W-1:0]  prev_req, last_req;
  int               req_count;

  task automatic clear_model();
    exp_q.delete();
    done_log.delete();
    outstanding = 0;
    exp_done    = 0;
    exp_ovf     = 0;
    prev_stall  = 0;
    req_count   = 0;
  endtask

  task automatic set_lane(input int i, input bit v, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input logic [POS_W-1:0] p);
    ret_valid[i]             = v;
    ret_addr[i*32 +: 32]     = a;
    ret_data[i*32 +: 32]     = d;
    ret_size[i*2 +: 2]       = s;
    ret_pos[i*POS_W +: POS_W] = p;
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < N_WAY; i++) set_lane(i, 0, '0, '0, '0, '0);
  endtask

  // Called at a falling edge with inputs already driven; checks the DUT against
  // the model, advances the model across the next rising edge, returns at the next falling edge.
  task automatic tick();
    logic [RQ_W-1:0] cur;
    logic [ST_W-1:0] popped;
    int free, n;
    bit was_out;
    #2;
    total++;
    if (free_slots !== CW'(DEPTH - exp_q.size())) begin
      bad++; $display("FAIL free_slots: got %0d want %0d", free_slots, DEPTH - exp_q.size());
    end
    total++;
    if (idle !== (exp_q.size() == 0)) begin
      bad++; $display("FAIL idle: got %b want %b", idle, exp_q.size() == 0);
    end
    total++;
    if (overflow_err !== exp_ovf) begin
      bad++; $display("FAIL overflow_err: got %b want %b", overflow_err, exp_ovf);
    end
    total++;
    if (done_valid !== exp_done) begin
      bad++; $display("FAIL done_valid: got %b want %b", done_valid, exp_done);
    end
    if (exp_done) begin
      total++;
      if (done_pos !== exp_done_pos) begin
        bad++; $display("FAIL done_pos: got %0d want %0d", done_pos, exp_done_pos);
      end
    end
    if (done_valid === 1'b1) done_log.push_back(done_pos);

    cur = {dc_req_addr, dc_req_data, dc_req_size};
    was_out = outstanding;
    if (prev_stall) begin
      total++;
      if (dc_req_valid !== 1'b1) begin
        bad++; $display("FAIL req_withdrawn: got valid=%b want 1", dc_req_valid);
      end
    end
    if (dc_req_valid === 1'b1) begin
      total++;
      if (outstanding || exp_q.size() == 0) begin
        bad++; $display("FAIL req_spurious: got valid=1 with outstanding=%0d buffered=%0d want 0", outstanding, exp_q.size());
      end else if (cur !== exp_q[0][ST_W-1:POS_W]) begin
        bad++; $display("FAIL req_fields: got %h want %h", cur, exp_q[0][ST_W-1:POS_W]);
      end
      if (prev_stall) begin
        total++;
        if (cur !== prev_req) begin
          bad++; $display("FAIL req_stable: got %h want %h", cur, prev_req);
        end
      end
      prev_req   = cur;
      prev_stall = (dc_req_ready !== 1'b1);
      if (dc_req_ready === 1'b1 && !outstanding) begin
        outstanding = 1;
        req_count++;
        last_req = cur;
      end
    end else begin
      prev_stall = 0;
    end

    free = DEPTH - exp_q.size();
    exp_done = 0;
    if (was_out && dc_ack === 1'b1) begin
      popped       = exp_q.pop_front();
      exp_done     = 1;
      exp_done_pos = popped[POS_W-1:0];
      outstanding  = 0;
    end
    n = 0;
    for (int i = 0; i < N_WAY; i++) begin
      if (ret_valid[i]) begin
        if (n < free) begin
          exp_q.push_back({ret_addr[i*32 +: 32], ret_data[i*32 +: 32], ret_size[i*2 +: 2], ret_pos[i*POS_W +: POS_W]});
          n++;
        end else begin
          exp_ovf = 1;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_lanes();
    dc_req_ready = 1'b0;
    dc_ack = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic drain(input bit rnd);
    int k;
    clear_lanes();
    k = 0;
    while ((exp_q.size() != 0 || exp_done) && k < 400) begin
      dc_req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dc_ack       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      k++;
    end
    total++;
    if (exp_q.size() != 0 || exp_done) begin
      bad++; $display("FAIL drain_timeout: got %0d entries left want 0", exp_q.size());
    end
    dc_req_ready = 1'b0;
    dc_ack = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", dc_req_valid); end
    total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL rst_done_valid: got %b want 0", done_valid); end
    total++; if (done_pos !== '0) begin bad++; $display("FAIL rst_done_pos: got %0d want 0", done_pos); end
    total++; if (free_slots !== CW'(DEPTH)) begin bad++; $display("FAIL rst_free_slots: got %0d want %0d", free_slots, DEPTH); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b want 1", idle); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow_err); end
  endtask

  task automatic test_single();
    int k;
    done_log.delete();
    req_count = 0;
    set_lane(0, 1, 32'h100, 32'hDEADBEEF, 2'd2, 4'd3);
    dc_req_ready = 1'b1;
    dc_ack = 1'b0;
    tick();
    clear_lanes();
    k = 0;
    while (!outstanding && k < 10) begin tick(); k++; end
    total++; if (!outstanding) begin bad++; $display("FAIL single_req_timeout: got no request want 1"); end
    tick();
    dc_ack = 1'b1;
    tick();
    dc_ack = 1'b0;
    tick();
    tick();
    total++; if (req_count != 1) begin bad++; $display("FAIL single_req_count: got %0d want 1", req_count); end
    total++; if (last_req !== {32'h100, 32'hDEADBEEF, 2'd2}) begin bad++; $display("FAIL single_req: got %h want %h", last_req, {32'h100, 32'hDEADBEEF, 2'd2}); end
    total++; if (done_log.size() != 1 || done_log[0] !== 4'd3) begin bad++; $display("FAIL single_done: got %0d pulses want 1 with pos 3", done_log.size()); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle: got %b want 1", idle); end
  endtask

  task automatic test_two_lanes();
    done_log.delete();
    total++; if (free_slots !== CW'(4)) begin bad++; $display("FAIL two_free_before: got %0d want 4", free_slots); end
    set_lane(0, 1, 32'h200, 32'h11111111, 2'd2, 4'd1);
    set_lane(1, 1, 32'h204, 32'h2222, 2'd1, 4'd2);
    dc_req_ready = 1'b0;
    tick();
    clear_lanes();
    total++; if (free_slots !== CW'(2)) begin bad++; $display("FAIL two_free_after: got %0d want 2", free_slots); end
    drain(0);
    total++; if (done_log.size() != 2 || done_log[0] !== 4'd1 || done_log[1] !== 4'd2) begin
      bad++; $display("FAIL two_order: got %0d pulses want pos 1 then 2", done_log.size());
    end
  endtask

  task automatic test_ready_stall();
    logic [RQ_W-1:0] snap;
    int k;
    set_lane(0, 1, 32'h300, 32'hCAFEF00D, 2'd0, 4'd9);
    dc_req_ready = 1'b0;
    dc_ack = 1'b1;
    tick();
    clear_lanes();
    k = 0;
    while (dc_req_valid !== 1'b1 && k < 10) begin tick(); k++; end
    snap = {dc_req_addr, dc_req_data, dc_req_size};
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if ({dc_req_addr, dc_req_data, dc_req_size} !== {32'h300, 32'hCAFEF00D, 2'd0} || snap !== {32'h300, 32'hCAFEF00D, 2'd0}) begin
        bad++; $display("FAIL stall_fields: got %h want %h", {dc_req_addr, dc_req_data, dc_req_size}, {32'h300, 32'hCAFEF00D, 2'd0});
      end
      total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL stall_done: got %b want 0", done_valid); end
      total++; if (free_slots !== CW'(3)) begin bad++; $display("FAIL stall_free: got %0d want 3", free_slots); end
    end
    drain(0);
  endtask

  task automatic test_wrap();
    int k;
    done_log.delete();
    for (int s = 0; s < 6; s++) begin
      k = 0;
      clear_lanes();
      while (free_slots == '0 && k < 50) begin
        dc_req_ready = 1'($urandom_range(0, 1)); dc_ack = 1'($urandom_range(0, 1));
        tick(); k++;
      end
      set_lane(0, 1, $urandom, $urandom, 2'($urandom_range(0, 2)), POS_W'(s + 1));
      dc_req_ready = 1'($urandom_range(0, 1));
      dc_ack = 1'($urandom_range(0, 1));
      tick();
      clear_lanes();
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        dc_req_ready = 1'($urandom_range(0, 1)); dc_ack = 1'($urandom_range(0, 1));
        tick();
      end
    end
    drain(1);
    total++;
    if (done_log.size() != 6) begin
      bad++; $display("FAIL wrap_count: got %0d want 6", done_log.size());
    end else begin
      for (int s = 0; s < 6; s++) begin
        total++;
        if (done_log[s] !== POS_W'(s + 1)) begin bad++; $display("FAIL wrap_order: got %0d want %0d", done_log[s], s + 1); end
      end
    end
  endtask

  task automatic test_overflow();
    done_log.delete();
    dc_req_ready = 1'b0;
    dc_ack = 1'b0;
    set_lane(0, 1, 32'h400, 32'hA1, 2'd2, 4'd1);
    set_lane(1, 1, 32'h404, 32'hA2, 2'd2, 4'd2);
    tick();
    set_lane(0, 1, 32'h408, 32'hA3, 2'd2, 4'd3);
    set_lane(1, 1, 32'h40C, 32'hA4, 2'd2, 4'd4);
    tick();
    set_lane(0, 1, 32'h410, 32'hA5, 2'd2, 4'd5);
    set_lane(1, 1, 32'h414, 32'hA6, 2'd2, 4'd6);
    tick();
    clear_lanes();
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow_err); end
    total++; if (free_slots !== '0) begin bad++; $display("FAIL ovf_free: got %0d want 0", free_slots); end
    drain(0);
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
    total++;
    if (done_log.size() != 4 || done_log[0] !== 4'd1 || done_log[1] !== 4'd2 || done_log[2] !== 4'd3 || done_log[3] !== 4'd4) begin
      bad++; $display("FAIL ovf_drain: got %0d pulses want pos 1,2,3,4", done_log.size());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N_WAY; i++)
        set_lane(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 2)), POS_W'($urandom_range(1, 15)));
      dc_req_ready = 1'($urandom_range(0, 1));
      dc_ack = 1'($urandom_range(0, 1));
      tick();
    end
    drain(1);
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rand_idle: got %b want 1", idle); end
    total++; if (free_slots !== CW'(DEPTH)) begin bad++; $display("FAIL rand_free: got %0d want %0d", free_slots, DEPTH); end
  endtask

  task automatic test_reset_in_wait();
    int k;
    dc_req_ready = 1'b0;
    dc_ack = 1'b0;
    set_lane(0, 1, 32'h500, 32'hB1, 2'd2, 4'd5);
    set_lane(1, 1, 32'h504, 32'hB2, 2'd2, 4'd6);
    tick();
    set_lane(0, 1, 32'h508, 32'hB3, 2'd2, 4'd7);
    set_lane(1, 0, '0, '0, '0, '0);
    tick();
    clear_lanes();
    dc_req_ready = 1'b1;
    k = 0;
    while (!outstanding && k < 10) begin tick(); k++; end
    total++; if (!outstanding) begin bad++; $display("FAIL rw_req_timeout: got no request want 1"); end
    total++; if (free_slots !== CW'(1)) begin bad++; $display("FAIL rw_free: got %0d want 1", free_slots); end
    reset = 1'b1;
    dc_ack = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    clear_model();
    dc_req_ready = 1'b1;
    dc_ack = 1'b1;
    total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL rw_req_valid: got %b want 0", dc_req_valid); end
    total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL rw_done_valid: got %b want 0", done_valid); end
    total++; if (done_pos !== '0) begin bad++; $display("FAIL rw_done_pos: got %0d want 0", done_pos); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rw_idle: got %b want 1", idle); end
    total++; if (free_slots !== CW'(DEPTH)) begin bad++; $display("FAIL rw_free_after: got %0d want %0d", free_slots, DEPTH); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL rw_overflow: got %b want 0", overflow_err); end
    tick();
    dc_ack = 1'b0;
    tick();
    tick();
    total++; if (done_log.size() != 0) begin bad++; $display("FAIL rw_late_ack: got %0d done pulses want 0", done_log.size()); end
  endtask

  initial begin
    reset = 1'b1;
    clear_lanes();
    dc_req_ready = 1'b0;
    dc_ack = 1'b0;
    clear_model();
    @(negedge clock);
    test_reset();
    test_single();
    test_two_lanes();
    test_ready_stall();
    test_wrap();
    test_overflow();
    apply_reset();
    test_random();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_commit_ctrl.md
STORE_COMMIT_CTRL -- requirements
Module: store_commit_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  N_WAY, 2, retire lanes per cycle
  DEPTH, 4, commit-buffer entries (power of two, >= N_WAY)
  POS_W, 4, width of a store-queue position (1-based; 0 = none)
REQ-002 The block SHALL have these ports (name direction width meaning):
  clock  input  1  clock; all state updates on the rising edge
  reset  input  1  reset, synchronous, active-high
  ret_valid  input  N_WAY  per-lane retiring-store valid, packed from lane 0
  ret_addr  input  N_WAY*32  per-lane store address
  ret_data  input  N_WAY*32  per-lane store data
  ret_size  input  N_WAY*2  per-lane MEM_SIZE (BYTE/HALF/WORD)
  ret_pos  input  N_WAY*POS_W  per-lane store-queue position
  free_slots  output  clog2(DEPTH)+1  empty commit-buffer entries
  dc_req_valid  output  1  D-cache write request valid
  dc_req_addr  output  32  request address
  dc_req_data  output  32  request data
  dc_req_size  output  2  request size
  dc_req_ready  input  1  D-cache accepted request this cycle
  dc_ack  input  1  D-cache write completed
  done_valid  output  1  one-cycle commit-complete pulse to store queue
  done_pos  output  POS_W  position of the completed store
  idle  output  1  buffer empty and FSM in IDLE
  overflow_err  output  1  sticky: a lane was dropped for lack of space

Function
REQ-003 The buffer SHALL be a circular FIFO of DEPTH entries {addr, data, size, pos} with head/tail pointers wrapping modulo DEPTH and a count of 0..DEPTH.
REQ-004 Each cycle, valid lanes SHALL be pushed in lane order 0..N_WAY-1 into consecutive tail slots; lane i is written only if fewer than free entries precede it.
REQ-005 A valid lane that finds no free entry SHALL be dropped and SHALL set overflow_err, which holds until reset.
REQ-006 free_slots SHALL equal DEPTH minus registered count (no same-cycle credit for pops).
REQ-007 The FSM SHALL have states IDLE, REQ, WAIT.
REQ-008 IDLE -> REQ when count > 0 at a clock edge; dc_req_valid SHALL be 1 exactly in REQ.
REQ-009 In REQ, dc_req_addr/data/size SHALL show the head entry and stay stable until dc_req_ready; on dc_req_ready the FSM SHALL go to WAIT.
REQ-010 In WAIT, on dc_ack the head SHALL pop, done_valid SHALL pulse for exactly the next cycle with done_pos = popped pos, and the FSM SHALL go to REQ if count after pop > 0 else IDLE.
REQ-011 dc_ack outside WAIT and dc_req_ready outside REQ SHALL be ignored.
REQ-012 Simultaneous push and pop SHALL update count by (pushed - 1); a full buffer with a pop SHALL NOT accept an extra lane that cycle (REQ-006 rule).
REQ-013 At most one request SHALL be outstanding; stores SHALL reach the D-cache in retire order.
REQ-014 idle SHALL be 1 iff count = 0 and state = IDLE.

Reset
REQ-015 On reset: head, tail, count = 0; state = IDLE; dc_req_valid, done_valid, overflow_err = 0; done_pos = 0; free_slots = DEPTH; idle = 1.
REQ-016 Reset mid-request SHALL discard all buffered stores and any outstanding request; a later dc_ack SHALL be ignored.

Configuration
REQ-017 Macro STORE_COMMIT_BYPASS_EN: when defined, if state = IDLE and count = 0, lane 0 SHALL be presented on dc_req in the same cycle it arrives (combinational bypass, FSM enters WAIT directly if dc_req_ready) while still being written into the buffer; when undefined, first request appears no earlier than the cycle after the push.

Verification
REQ-018 Single store addr 0x100 data 0xDEADBEEF WORD pos 3, ready=1, ack 2 cycles later -> one request with those fields, done_valid pulse with done_pos=3, idle returns 1.
REQ-019 Two lanes valid (pos 1, 2) in one cycle -> free_slots drops from 4 to 2; requests issued pos 1 then pos 2; done pulses in that order.
REQ-020 Hold dc_req_ready=0 for 5 cycles -> dc_req fields unchanged all 5 cycles; no pop, no done pulse.
REQ-021 Fill 4 entries, then push 2 more with buffer full -> both dropped, overflow_err=1, count stays 4; drain delivers original 4 only.
REQ-022 Wrap-around: 6 stores pushed/drained over time with DEPTH=4 -> commit order matches retire order across pointer wrap.
REQ-023 Assert reset while in WAIT with 3 entries, then pulse dc_ack -> all outputs at reset values, no done pulse.
